// File: rtl/soc_msp430_ram_arb_pkg.sv
// Shared constants and types for the two-master RAM port arbiter.
package soc_msp430_ram_arb_pkg;

    localparam logic [1:0] RD_EN     = 2'b11;
    localparam logic [1:0] WEN_ALL   = 2'b00;
    localparam int         ARB_FIXED = 0;
    localparam int         ARB_RR    = 1;

    typedef logic arb_id_t;

endpackage

// File: rtl/soc_msp430_arb_rr2.sv
// Two-way grant generator, fixed priority or round-robin, with the last_grant register.
module soc_msp430_arb_rr2
    import soc_msp430_ram_arb_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR
) (
    input  logic mclk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    output logic gnt_vld,
    output logic gnt_id
);

    arb_id_t last_grant;

    // Grants are masked while reset is low so every output sits at its reset value.
    always_comb begin
        gnt_vld = reset_n && (req0 || req1);
        gnt_id  = 1'b0;
        if (req0 && req1) begin
            gnt_id = (ARB_MODE == ARB_RR) ? ~last_grant : 1'b0;
        end else if (req1) begin
            gnt_id = 1'b1;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (gnt_vld) begin
            last_grant <= gnt_id;
        end
    end

endmodule

// File: rtl/soc_msp430_ram_arb.sv
// Shares one MSP430 data RAM port between two masters; returns read data one cycle after accept.
module soc_msp430_ram_arb
    import soc_msp430_ram_arb_pkg::*;
#(
    parameter int ADDR_MSB = 6,
    parameter int MEM_SIZE = 256,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic                mclk,
    input  logic                reset_n,
    input  logic                req0,
    input  logic                req1,
    input  logic [ADDR_MSB:0]   addr0,
    input  logic [ADDR_MSB:0]   addr1,
    input  logic [1:0]          wen0,
    input  logic [1:0]          wen1,
    input  logic [15:0]         din0,
    input  logic [15:0]         din1,
    output logic                ready0,
    output logic                ready1,
    output logic [15:0]         rdata0,
    output logic [15:0]         rdata1,
    output logic                rvalid0,
    output logic                rvalid1,
    output logic [ADDR_MSB:0]   ram_addr,
    output logic                ram_cen,
    output logic [1:0]          ram_wen,
    output logic [15:0]         ram_din,
    input  logic [15:0]         ram_dout
);

    localparam int ADDR_W = ADDR_MSB + 1;
    localparam int WORDS  = MEM_SIZE / 2;

    logic          gnt_vld;
    arb_id_t       gnt_id;
    logic [ADDR_MSB:0] sel_addr;
    logic [1:0]    sel_wen;
    logic [15:0]   sel_din;
    logic          in_range;
    logic          rd_acc;
    logic          rd_pend0, rd_pend1, oob_rd;
    logic [15:0]   rdata_q0, rdata_q1;
    logic [15:0]   ret_data;

    soc_msp430_arb_rr2 #(.ARB_MODE(ARB_MODE)) u_arb (
        .mclk    (mclk),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    always_comb begin
        sel_addr = gnt_id ? addr1 : addr0;
        sel_wen  = gnt_id ? wen1  : wen0;
        sel_din  = gnt_id ? din1  : din0;
    end

    // When the address bus cannot reach past the RAM, every address is valid.
    generate
        if ((1 << ADDR_W) <= WORDS) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_range_chk
            assign in_range = sel_addr < ADDR_W'(WORDS);
        end
    endgenerate

    always_comb begin
        ready0   = gnt_vld && !gnt_id;
        ready1   = gnt_vld && gnt_id;
        ram_cen  = !(gnt_vld && in_range);
        ram_wen  = gnt_vld ? sel_wen  : RD_EN;
        ram_addr = gnt_vld ? sel_addr : '0;
        ram_din  = gnt_vld ? sel_din  : 16'h0000;
        rd_acc   = gnt_vld && (sel_wen == RD_EN);
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
            oob_rd   <= 1'b0;
            rdata_q0 <= 16'h0000;
            rdata_q1 <= 16'h0000;
        end else begin
            rd_pend0 <= rd_acc && !gnt_id;
            rd_pend1 <= rd_acc && gnt_id;
            oob_rd   <= rd_acc && !in_range;
            if (rd_pend0) rdata_q0 <= ret_data;
            if (rd_pend1) rdata_q1 <= ret_data;
        end
    end

    // The RAM output is only live in the return cycle, so it bypasses the hold register then.
    always_comb begin
        ret_data = oob_rd ? 16'h0000 : ram_dout;
        rvalid0  = rd_pend0;
        rvalid1  = rd_pend1;
        rdata0   = rd_pend0 ? ret_data : rdata_q0;
        rdata1   = rd_pend1 ? ret_data : rdata_q1;
    end

endmodule

// File: tb/tb_soc_msp430_ram_arb.sv
// Bench for the RAM port arbiter: a round-robin instance with an 8-bit address bus and a
// fixed-priority instance with the default 7-bit bus share one set of master stimulus.
module tb_soc_msp430_ram_arb;
    import soc_msp430_ram_arb_pkg::*;

    logic        mclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  addr0 = 8'h00, addr1 = 8'h00;
    logic [1:0]  wen0 = 2'b11, wen1 = 2'b11;
    logic [15:0] din0 = 16'h0, din1 = 16'h0;

    logic        rdy0_r, rdy1_r, rv0_r, rv1_r, cen_r;
    logic [15:0] rd0_r, rd1_r, din_r, dout_r;
    logic [1:0]  wen_r;
    logic [7:0]  r_addr;
    logic        rdy0_f, rdy1_f, rv0_f, rv1_f, cen_f;
    logic [15:0] rd0_f, rd1_f, din_f, dout_f;
    logic [1:0]  wen_f;
    logic [6:0]  f_addr;

    logic [15:0] mem_r [128];
    logic [15:0] mem_f [128];

    // Reference model state: expected RAM contents, arbitration history, read returns.
    logic [15:0] shadow [2][128];
    logic        lg [2];
    logic [15:0] hold [2][2];
    logic [17:0] exp_q [$];
    logic        got0, got1;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 mclk = ~mclk;

    soc_msp430_ram_arb #(.ADDR_MSB(7), .MEM_SIZE(256), .ARB_MODE(ARB_RR)) dut_rr (
        .mclk(mclk), .reset_n(reset_n), .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1), .wen0(wen0), .wen1(wen1), .din0(din0), .din1(din1),
        .ready0(rdy0_r), .ready1(rdy1_r), .rdata0(rd0_r), .rdata1(rd1_r),
        .rvalid0(rv0_r), .rvalid1(rv1_r), .ram_addr(r_addr), .ram_cen(cen_r),
        .ram_wen(wen_r), .ram_din(din_r), .ram_dout(dout_r)
    );

    soc_msp430_ram_arb #(.ADDR_MSB(6), .MEM_SIZE(256), .ARB_MODE(ARB_FIXED)) dut_fp (
        .mclk(mclk), .reset_n(reset_n), .req0(req0), .req1(req1),
        .addr0(addr0[6:0]), .addr1(addr1[6:0]), .wen0(wen0), .wen1(wen1), .din0(din0), .din1(din1),
        .ready0(rdy0_f), .ready1(rdy1_f), .rdata0(rd0_f), .rdata1(rd1_f),
        .rvalid0(rv0_f), .rvalid1(rv1_f), .ram_addr(f_addr), .ram_cen(cen_f),
        .ram_wen(wen_f), .ram_din(din_f), .ram_dout(dout_f)
    );

    // RAM port models: registered read of the old word, low-active byte writes.
    always @(posedge mclk) begin
        if (!cen_r) begin
            dout_r <= mem_r[r_addr[6:0]];
            if (!wen_r[0]) mem_r[r_addr[6:0]][7:0]  <= din_r[7:0];
            if (!wen_r[1]) mem_r[r_addr[6:0]][15:8] <= din_r[15:8];
        end
    end

    always @(posedge mclk) begin
        if (!cen_f) begin
            dout_f <= mem_f[f_addr];
            if (!wen_f[0]) mem_f[f_addr][7:0]  <= din_f[7:0];
            if (!wen_f[1]) mem_f[f_addr][15:8] <= din_f[15:8];
        end
    end

    // Checks one cycle of both DUTs against the model, then advances to the next cycle.
    task automatic cycle();
        logic        ev [2][2];
        logic [17:0] e;
        logic        any, g, inr;
        logic [7:0]  a;
        logic [1:0]  w;
        logic [15:0] dn;
        logic [28:0] act_port, exp_port;
        logic [33:0] act_ret, exp_ret;
        #1;
        ev = '{default: 1'b0};
        got0 = 1'b0;
        got1 = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ev[e[17]][e[16]] = 1'b1;
            hold[e[17]][e[16]] = e[15:0];
        end
        for (int d = 0; d < 2; d++) begin
            any = reset_n && (req0 || req1);
            if (req0 && req1) g = (d == 0) ? !lg[0] : 1'b0;
            else              g = req1;
            a   = g ? addr1 : addr0;
            if (d == 1) a[7] = 1'b0;
            w   = g ? wen1 : wen0;
            dn  = g ? din1 : din0;
            inr = (a < 8'd128);
            exp_port = {any && !g, any && g, !(any && inr), any ? w : 2'b11,
                        any ? a : 8'h00, any ? dn : 16'h0000};
            act_port = (d == 0) ? {rdy0_r, rdy1_r, cen_r, wen_r, r_addr, din_r}
                                : {rdy0_f, rdy1_f, cen_f, wen_f, 1'b0, f_addr, din_f};
            n_vec++;
            if (act_port !== exp_port) begin
                n_err++;
                $display("FAIL port dut%0d t=%0t: got %h, expected %h", d, $time, act_port, exp_port);
            end
            exp_ret = {ev[d][0], ev[d][1], hold[d][0], hold[d][1]};
            act_ret = (d == 0) ? {rv0_r, rv1_r, rd0_r, rd1_r} : {rv0_f, rv1_f, rd0_f, rd1_f};
            n_vec++;
            if (act_ret !== exp_ret) begin
                n_err++;
                $display("FAIL return dut%0d t=%0t: got %h, expected %h", d, $time, act_ret, exp_ret);
            end
            if (any) begin
                if (w == 2'b11) begin
                    exp_q.push_back({d[0], g, inr ? shadow[d][a[6:0]] : 16'h0000});
                end else if (inr) begin
                    if (!w[0]) shadow[d][a[6:0]][7:0]  = dn[7:0];
                    if (!w[1]) shadow[d][a[6:0]][15:8] = dn[15:8];
                end
                lg[d] = g;
                if (d == 0) begin
                    got0 = !g;
                    got1 = g;
                end
            end
        end
        @(posedge mclk);
        @(negedge mclk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        hold = '{default: 16'h0000};
        lg   = '{default: 1'b1};
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        model_reset();
        repeat (2) @(negedge mclk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic mem_check(input string tag);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < 128; i++) begin
            if (mem_r[i] !== shadow[0][i] || mem_f[i] !== shadow[1][i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL %s: %0d RAM words differ, first at word %0d (rr %h/%h, fp %h/%h)", tag, bad,
                     first, mem_r[first], shadow[0][first], mem_f[first], shadow[1][first]);
        end
    endtask

    task automatic test_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        addr0 = 8'h33;
        din0 = 16'h5555;
        #2;
        n_vec++;
        if ({rdy0_r, rdy1_r, rv0_r, rv1_r, cen_r, wen_r, r_addr, din_r, rd0_r, rd1_r} !==
            {4'b0000, 1'b1, 2'b11, 8'h00, 16'h0, 16'h0, 16'h0}) begin
            n_err++;
            $display("FAIL reset_rr: got rdy=%b%b rv=%b%b cen=%b wen=%b addr=%h din=%h, expected all idle",
                     rdy0_r, rdy1_r, rv0_r, rv1_r, cen_r, wen_r, r_addr, din_r);
        end
        n_vec++;
        if ({rdy0_f, rdy1_f, rv0_f, rv1_f, cen_f, wen_f, f_addr, din_f, rd0_f, rd1_f} !==
            {4'b0000, 1'b1, 2'b11, 7'h00, 16'h0, 16'h0, 16'h0}) begin
            n_err++;
            $display("FAIL reset_fp: got rdy=%b%b rv=%b%b cen=%b wen=%b addr=%h din=%h, expected all idle",
                     rdy0_f, rdy1_f, rv0_f, rv1_f, cen_f, wen_f, f_addr, din_f);
        end
        cycle();
        do_reset();
    endtask

    task automatic test_write_read();
        req0 = 1'b1; addr0 = 8'h05; wen0 = WEN_ALL; din0 = 16'hA55A;
        #1;
        n_vec++;
        if ({rdy0_r, rdy0_f} !== 2'b11) begin
            n_err++;
            $display("FAIL wr_ready0: got %b, expected 11", {rdy0_r, rdy0_f});
        end
        cycle();
        wen0 = RD_EN;
        cycle();
        req0 = 1'b0;
        n_vec++;
        if ({rv0_r, rv1_r, rd0_r, rv0_f, rv1_f, rd0_f} !== {2'b10, 16'hA55A, 2'b10, 16'hA55A}) begin
            n_err++;
            $display("FAIL wr_rd_return: got rr %b%b %h fp %b%b %h, expected 10 a55a",
                     rv0_r, rv1_r, rd0_r, rv0_f, rv1_f, rd0_f);
        end
        cycle();
    endtask

    task automatic test_byte_write();
        req1 = 1'b1; addr1 = 8'h10; wen1 = WEN_ALL; din1 = 16'h1234;
        cycle();
        wen1 = 2'b10; din1 = 16'hFFCD;
        cycle();
        wen1 = RD_EN;
        cycle();
        req1 = 1'b0;
        n_vec++;
        if ({rv1_r, rd1_r, rv1_f, rd1_f} !== {1'b1, 16'h12CD, 1'b1, 16'h12CD}) begin
            n_err++;
            $display("FAIL byte_write: got rr %b %h fp %b %h, expected 1 12cd", rv1_r, rd1_r, rv1_f, rd1_f);
        end
        cycle();
    endtask

    task automatic test_contention();
        do_reset();
        req0 = 1'b1; addr0 = 8'h01; wen0 = RD_EN;
        req1 = 1'b1; addr1 = 8'h02; wen1 = RD_EN;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_vec++;
            if ({rdy0_r, rdy1_r, rdy0_f, rdy1_f} !== {(k % 2) == 0, (k % 2) == 1, 2'b10}) begin
                n_err++;
                $display("FAIL contention_grant k=%0d: got rr %b%b fp %b%b", k, rdy0_r, rdy1_r, rdy0_f, rdy1_f);
            end
            if (k > 0) begin
                n_vec++;
                if ({rv0_r, rv1_r} !== {(k % 2) == 1, (k % 2) == 0}) begin
                    n_err++;
                    $display("FAIL contention_rvalid k=%0d: got %b%b", k, rv0_r, rv1_r);
                end
            end
            cycle();
        end
        req0 = 1'b0;
        #1;
        n_vec++;
        if (rdy1_f !== 1'b1) begin
            n_err++;
            $display("FAIL fixed_release: ready1 got %b, expected 1", rdy1_f);
        end
        cycle();
        req1 = 1'b0;
        cycle();
    endtask

    task automatic test_oob();
        req0 = 1'b1; addr0 = 8'h7F; wen0 = RD_EN;
        #1;
        n_vec++;
        if ({rdy0_r, cen_r} !== 2'b10) begin
            n_err++;
            $display("FAIL oob_7f: got ready/cen %b%b, expected 10", rdy0_r, cen_r);
        end
        cycle();
        addr0 = 8'h80;
        #1;
        n_vec++;
        if ({rdy0_r, cen_r} !== 2'b11) begin
            n_err++;
            $display("FAIL oob_80_read: got ready/cen %b%b, expected 11", rdy0_r, cen_r);
        end
        cycle();
        wen0 = WEN_ALL; din0 = 16'hBEEF;
        #1;
        n_vec++;
        if ({rv0_r, rd0_r, cen_r} !== {1'b1, 16'h0000, 1'b1}) begin
            n_err++;
            $display("FAIL oob_80_return: got rv=%b rdata=%h cen=%b, expected 1 0000 1", rv0_r, rd0_r, cen_r);
        end
        cycle();
        req0 = 1'b0;
        cycle();
        mem_check("oob_write");
    endtask

    task automatic test_back_to_back();
        req0 = 1'b1; addr0 = 8'h20; wen0 = WEN_ALL; din0 = 16'h1111;
        cycle();
        wen0 = RD_EN;
        cycle();
        wen0 = WEN_ALL; din0 = 16'h2222;
        #1;
        n_vec++;
        if ({rv0_r, rd0_r} !== {1'b1, 16'h1111}) begin
            n_err++;
            $display("FAIL rd_then_wr: got %b %h, expected 1 1111", rv0_r, rd0_r);
        end
        cycle();
        wen0 = RD_EN;
        cycle();
        req0 = 1'b0;
        n_vec++;
        if ({rv0_r, rd0_r} !== {1'b1, 16'h2222}) begin
            n_err++;
            $display("FAIL wr_then_rd: got %b %h, expected 1 2222", rv0_r, rd0_r);
        end
        cycle();
    endtask

    task automatic test_reset_mid_read();
        req0 = 1'b1; addr0 = 8'h05; wen0 = RD_EN;
        cycle();
        req0 = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({rv0_r, rv0_f, rd0_r, rd0_f, cen_r, cen_f} !== {2'b00, 16'h0, 16'h0, 2'b11}) begin
            n_err++;
            $display("FAIL reset_mid_read: got rv %b%b rdata %h %h cen %b%b, expected 00 0 0 11",
                     rv0_r, rv0_f, rd0_r, rd0_f, cen_r, cen_f);
        end
        cycle();
        reset_n = 1'b1;
        req0 = 1'b1; addr0 = 8'h03;
        req1 = 1'b1; addr1 = 8'h04; wen1 = RD_EN;
        #1;
        n_vec++;
        if ({rdy0_r, rdy1_r} !== 2'b10) begin
            n_err++;
            $display("FAIL post_reset_grant: got %b%b, expected 10", rdy0_r, rdy1_r);
        end
        cycle();
        cycle();
        req0 = 1'b0;
        req1 = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        got0 = 1'b1;
        got1 = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (!req0 || got0) begin
                req0  = ($urandom_range(0, 3) != 0);
                addr0 = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
                wen0  = 2'($urandom_range(0, 3));
                din0  = 16'($urandom);
            end
            if (!req1 || got1) begin
                req1  = ($urandom_range(0, 3) != 0);
                addr1 = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
                wen1  = 2'($urandom_range(0, 3));
                din1  = 16'($urandom);
            end
            cycle();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        cycle();
        cycle();
        mem_check("random_ram");
    endtask

    initial begin
        logic [15:0] v;
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 128; i++) begin
            v = 16'($urandom);
            mem_r[i] <= v;
            mem_f[i] <= v;
            shadow[0][i] = v;
            shadow[1][i] = v;
        end
        test_reset();
        test_write_read();
        test_byte_write();
        test_contention();
        test_oob();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
